comparator_arbiter: RTL and testbench

- Shares one Comparator instance (unsigned, N-bit) among R requesters.
- Round-robin arbitration; the winner's operands and condition code are registered into the comparator.
- The selected condition is returned with the full flag set and owner ID.
- Sits between the branch/compare issuers (execute stage, test-and-set unit) and the single comparator datapath.

---
 rtl/comparator_pkg.sv | 30 +++
 rtl/comparator.sv | 22 ++
 rtl/round_robin_picker.sv | 32 +++
 rtl/comparator_arbiter.sv | 133 +++++++++++++
 tb/tb_comparator_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/comparator_pkg.sv
// Shared constants for the comparator arbiter: condition codes, flag bit
// positions and FSM state encoding.
package comparator_pkg;

   localparam int COND_W = 3;

   localparam logic [COND_W-1:0] COND_GT     = 3'd0;
   localparam logic [COND_W-1:0] COND_EQ     = 3'd1;
   localparam logic [COND_W-1:0] COND_LT     = 3'd2;
   localparam logic [COND_W-1:0] COND_GE     = 3'd3;
   localparam logic [COND_W-1:0] COND_NE     = 3'd4;
   localparam logic [COND_W-1:0] COND_LE     = 3'd5;
   localparam logic [COND_W-1:0] COND_ALWAYS = 3'd6;
   localparam logic [COND_W-1:0] COND_NEVER  = 3'd7;

   // Flag vector is {greater, equal, less, greater_equal, not_equal, less_equal}
   localparam int FLAG_W  = 6;
   localparam int FLAG_GT = 5;
   localparam int FLAG_EQ = 4;
   localparam int FLAG_LT = 3;
   localparam int FLAG_GE = 2;
   localparam int FLAG_NE = 1;
   localparam int FLAG_LE = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EVAL = 1'b1
   } state_t;

endpackage

// File: rtl/comparator.sv
// Unsigned N-bit magnitude comparator producing the full six-flag vector.
module comparator
   import comparator_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]      left,
   input  logic [N-1:0]      right,
   output logic [FLAG_W-1:0] flags
);

   always_comb begin
      flags          = '0;
      flags[FLAG_GT] = (left >  right);
      flags[FLAG_EQ] = (left == right);
      flags[FLAG_LT] = (left <  right);
      flags[FLAG_GE] = (left >= right);
      flags[FLAG_NE] = (left != right);
      flags[FLAG_LE] = (left <= right);
   end

endmodule

// File: rtl/round_robin_picker.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping modulo R.
module round_robin_picker #(
   parameter  int R   = 4,
   localparam int R_W = $clog2(R)
) (
   input  logic [R-1:0]   request,
   input  logic [R_W-1:0] pointer,
   output logic [R-1:0]   winner,
   output logic [R_W-1:0] index,
   output logic           any
);

   int slot;

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      winner = '0;
      index  = '0;
      any    = 1'b0;
      slot   = 0;
      for (int i = 0; i < R; i++) begin
         slot = (int'(pointer) + i) % R;
         if (!any && request[slot]) begin
            any          = 1'b1;
            winner[slot] = 1'b1;
            index        = R_W'(slot);
         end
      end
   end

endmodule

// File: rtl/comparator_arbiter.sv
// Shares one unsigned comparator among R requesters with round-robin
// arbitration; two-state FSM (IDLE captures a winner, EVAL returns its result).
module comparator_arbiter
   import comparator_pkg::*;
#(
   parameter  int N   = 4,
   parameter  int R   = 4,
   localparam int R_W = $clog2(R)
) (
   input  logic                i_clock,
   input  logic                i_reset_n,
   input  logic [R-1:0]        i_request,
   input  logic [R*N-1:0]      i_left,
   input  logic [R*N-1:0]      i_right,
   input  logic [R*COND_W-1:0] i_condition,
   output logic [R-1:0]        o_grant,
   output logic                o_busy,
   output logic                o_valid,
   output logic [R_W-1:0]      o_owner,
   output logic                o_result,
   output logic [FLAG_W-1:0]   o_flags
);

   state_t              state;
   state_t              state_next;
   logic [R_W-1:0]      pointer;
   logic [R_W-1:0]      pointer_next;
   logic [N-1:0]        op_left;
   logic [N-1:0]        op_right;
   logic [COND_W-1:0]   op_cond;
   logic [R_W-1:0]      op_owner;
   logic [R-1:0]        pick_onehot;
   logic [R_W-1:0]      pick_index;
   logic                pick_any;
   logic [FLAG_W-1:0]   flags;
   logic                cond_result;
   logic                load;
   logic                done;

   round_robin_picker #(.R(R)) u_picker (
      .request (i_request),
      .pointer (pointer),
      .winner  (pick_onehot),
      .index   (pick_index),
      .any     (pick_any)
   );

   comparator #(.N(N)) u_comparator (
      .left  (op_left),
      .right (op_right),
      .flags (flags)
   );

   always_comb begin
      state_next = state;
      load       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               load       = 1'b1;
               state_next = ST_EVAL;
            end
         end
         ST_EVAL: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cond_result = 1'b0;
      case (op_cond)
         COND_GT:     cond_result = flags[FLAG_GT];
         COND_EQ:     cond_result = flags[FLAG_EQ];
         COND_LT:     cond_result = flags[FLAG_LT];
         COND_GE:     cond_result = flags[FLAG_GE];
         COND_NE:     cond_result = flags[FLAG_NE];
         COND_LE:     cond_result = flags[FLAG_LE];
         COND_ALWAYS: cond_result = 1'b1;
         default:     cond_result = 1'b0;
      endcase
   end

   // Explicit wrap keeps the rotation correct when R is not a power of two.
   assign pointer_next = (op_owner == R_W'(R - 1)) ? '0 : op_owner + 1'b1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pointer  <= '0;
         op_left  <= '0;
         op_right <= '0;
         op_cond  <= '0;
         op_owner <= '0;
         o_grant  <= '0;
         o_busy   <= 1'b0;
         o_valid  <= 1'b0;
         o_owner  <= '0;
         o_result <= 1'b0;
         o_flags  <= '0;
      end else begin
         o_grant <= load ? pick_onehot : '0;
         o_busy  <= load;
         o_valid <= done;
         if (load) begin
            op_left  <= i_left[pick_index*N +: N];
            op_right <= i_right[pick_index*N +: N];
            op_cond  <= i_condition[pick_index*COND_W +: COND_W];
            op_owner <= pick_index;
         end
         // Result fields hold between pulses; consumers qualify with o_valid.
         if (done) begin
            o_owner  <= op_owner;
            o_result <= cond_result;
            o_flags  <= flags;
            pointer  <= pointer_next;
         end
      end
   end

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed plus randomized bench for comparator_arbiter, checked against a
// transaction-level reference model.
module tb_comparator_arbiter;
   import comparator_pkg::*;

   localparam int N   = 4;
   localparam int R   = 4;
   localparam int R_W = $clog2(R);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [R-1:0]      req = '0;
   logic [R*N-1:0]    left = '0;
   logic [R*N-1:0]    right = '0;
   logic [R*3-1:0]    cond = '0;
   logic [R-1:0]      o_grant;
   logic              o_busy;
   logic              o_valid;
   logic [R_W-1:0]    o_owner;
   logic              o_result;
   logic [5:0]        o_flags;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int          m_ptr = 0;
   bit          m_busy = 0;
   int          m_owner = 0;
   int          m_l = 0, m_r = 0, m_c = 0;
   logic [R-1:0] e_grant = '0;
   bit          e_busy = 0, e_valid = 0, e_result = 0;
   int          e_owner = 0;
   logic [5:0]  e_flags = '0;
   logic [R-1:0] keep = '0;

   always #5 clk = ~clk;

   comparator_arbiter #(.N(N), .R(R)) dut (
      .i_clock     (clk),
      .i_reset_n   (rst_n),
      .i_request   (req),
      .i_left      (left),
      .i_right     (right),
      .i_condition (cond),
      .o_grant     (o_grant),
      .o_busy      (o_busy),
      .o_valid     (o_valid),
      .o_owner     (o_owner),
      .o_result    (o_result),
      .o_flags     (o_flags)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] ref_flags(input int a, input int b);
      return {a > b, a == b, a < b, a >= b, a != b, a <= b};
   endfunction

   function automatic bit ref_result(input int c, input int a, input int b);
      case (c)
         0: return a > b;
         1: return a == b;
         2: return a < b;
         3: return a >= b;
         4: return a != b;
         5: return a <= b;
         6: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_busy = 0; m_owner = 0;
      e_grant = '0; e_busy = 0; e_valid = 0; e_result = 0; e_owner = 0; e_flags = '0;
   endtask

   // Predict the outputs that follow the coming clock edge.
   task automatic predict();
      bit found;
      int k;
      e_valid = 0;
      e_grant = '0;
      e_busy  = 0;
      if (!m_busy) begin
         found = 0;
         for (int i = 0; i < R; i++) begin
            k = (m_ptr + i) % R;
            if (!found && req[k]) begin
               found = 1;
               m_owner = k;
               m_l = int'(left[k*N +: N]);
               m_r = int'(right[k*N +: N]);
               m_c = int'(cond[k*3 +: 3]);
               e_grant[k] = 1'b1;
               e_busy = 1;
               m_busy = 1;
            end
         end
      end else begin
         e_valid  = 1;
         e_owner  = m_owner;
         e_flags  = ref_flags(m_l, m_r);
         e_result = ref_result(m_c, m_l, m_r);
         m_ptr    = (m_owner + 1) % R;
         m_busy   = 0;
      end
   endtask

   task automatic cycle();
      predict();
      @(posedge clk);
      #1;
      check("grant", 32'(o_grant), 32'(e_grant));
      check("busy", 32'(o_busy), 32'(e_busy));
      check("valid", 32'(o_valid), 32'(e_valid));
      check("owner", 32'(o_owner), 32'(e_owner));
      check("result", 32'(o_result), 32'(e_result));
      check("flags", 32'(o_flags), 32'(e_flags));
      for (int k = 0; k < R; k++)
         if (e_grant[k] && !keep[k]) req[k] = 1'b0;
   endtask

   task automatic issue(input int k, input int l, input int r, input int c);
      left[k*N +: N] = N'(l);
      right[k*N +: N] = N'(r);
      cond[k*3 +: 3] = 3'(c);
      req[k] = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"}, 32'(o_grant), 0);
      check({tag, "_busy"}, 32'(o_busy), 0);
      check({tag, "_valid"}, 32'(o_valid), 0);
      check({tag, "_owner"}, 32'(o_owner), 0);
      check({tag, "_result"}, 32'(o_result), 0);
      check({tag, "_flags"}, 32'(o_flags), 0);
   endtask

   initial begin
      int cond_exp [8] = '{0, 1, 0, 1, 0, 1, 1, 0};

      // Reset state
      #1;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // All requesters active from pointer 0: strict rotation 0,1,2,3,0
      keep = '1;
      for (int k = 0; k < R; k++) issue(k, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      for (int s = 0; s < 5; s++) begin
         cycle();
         check("rr_order", 32'(o_grant), 32'(1 << (s % R)));
         cycle();
      end
      keep = '0;
      req = '0;
      cycle();
      cycle();

      // Single request: requester 2, 9 > 3
      issue(2, 9, 3, 0);
      cycle();
      check("single_grant", 32'(o_grant), 32'b0100);
      cycle();
      check("single_valid", 32'(o_valid), 1);
      check("single_owner", 32'(o_owner), 2);
      check("single_result", 32'(o_result), 1);
      check("single_flags", 32'(o_flags), 32'b100110);

      // Every condition code with equal operands
      for (int c = 0; c < 8; c++) begin
         issue(3, 5, 5, c);
         cycle();
         cycle();
         check("cond_eq_result", 32'(o_result), 32'(cond_exp[c]));
      end
      issue(1, 0, 15, 2);
      cycle(); cycle();
      check("lt_0_15", 32'(o_result), 1);
      issue(1, 0, 15, 4);
      cycle(); cycle();
      check("ne_0_15", 32'(o_result), 1);
      issue(0, 15, 0, 3);
      cycle(); cycle();
      check("flags_max_0", 32'(o_flags), 32'b100110);
      issue(0, 0, 0, 5);
      cycle(); cycle();
      check("flags_0_0", 32'(o_flags), 32'b010101);

      // Back-to-back from one requester held for six cycles
      keep[0] = 1'b1;
      issue(0, 3, 7, 2);
      for (int i = 1; i <= 6; i++) begin
         cycle();
         check("b2b_grant", 32'(o_grant[0]), 32'(i % 2));
         check("b2b_valid", 32'(o_valid), 32'(i % 2 == 0));
         if (i == 5) begin
            keep[0] = 1'b0;
            req[0] = 1'b0;
         end
      end

      // Operands change after capture
      issue(1, 12, 4, 0);
      cycle();
      left[1*N +: N] = 4'd0;
      right[1*N +: N] = 4'd15;
      cycle();
      check("capture_flags", 32'(o_flags), 32'b100110);
      check("capture_result", 32'(o_result), 1);

      // Reset during EVAL drops the operation
      issue(3, 7, 2, 0);
      cycle();
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      cycle();
      issue(1, 6, 6, 1);
      cycle();
      check("post_reset_grant", 32'(o_grant), 32'b0010);
      cycle();
      check("post_reset_owner", 32'(o_owner), 1);
      check("post_reset_result", 32'(o_result), 1);

      // Randomized traffic obeying the hold rule
      for (int t = 0; t < 400; t++) begin
         cycle();
         keep = R'($urandom);
         for (int k = 0; k < R; k++) begin
            if (!req[k]) begin
               left[k*N +: N] = N'($urandom);
               right[k*N +: N] = N'($urandom);
               cond[k*3 +: 3] = 3'($urandom);
               if ($urandom_range(0, 2) == 0) req[k] = 1'b1;
            end
         end
      end
      keep = '0;
      req = '0;
      cycle();
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
